// File: rtl/trace_capture_buffer_if.sv
// Bundle of signals between a trace capture buffer and its surroundings.
//   Capture side (from the CPU, observe only): arm, cap_en, trig_addr, addr_in, result_in
//   Read side (to the host or display):        rd_ready in; rd_valid, rd_addr, rd_result out
//   Status:                                    count, full, state
// The slave modport is the buffer itself. The master modport is whatever drives
// the CPU taps and consumes the read port.
interface trace_capture_buffer_if #(
  parameter int AW = 4
);
  logic          arm;
  logic          cap_en;
  logic [31:0]   trig_addr;
  logic [31:0]   addr_in;
  logic [31:0]   result_in;
  logic          rd_ready;
  logic          rd_valid;
  logic [31:0]   rd_addr;
  logic [31:0]   rd_result;
  logic [AW:0]   count;
  logic          full;
  logic [1:0]    state;

  modport master (
    output arm, cap_en, trig_addr, addr_in, result_in, rd_ready,
    input  rd_valid, rd_addr, rd_result, count, full, state
  );

  modport slave (
    input  arm, cap_en, trig_addr, addr_in, result_in, rd_ready,
    output rd_valid, rd_addr, rd_result, count, full, state
  );
endinterface

// File: rtl/trace_capture_buffer.sv
// Debug trace buffer that sits beside a single-cycle CPU. Once armed, it waits
// for the CPU to execute the instruction at trig_addr. From that instruction on,
// it records {addr_in, result_in} for every executed instruction into a
// first-word-fall-through FIFO. When the FIFO fills without being drained, the
// buffer freezes. It returns to idle once the frozen contents have been read out.
// It never stalls the CPU.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset; discards all captured entries
//   bus    trace_capture_buffer_if.slave (capture taps, read port, status)
module trace_capture_buffer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  trace_capture_buffer_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_FROZEN  = 2'd3
  } state_t;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  state_t         state_q;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count_q;
  logic           full_q;
  logic           vld_q;

  // Entry layout: {addr[31:0], result[31:0]}. Data storage has no reset.
  logic [63:0]    mem [DEPTH];
  logic [63:0]    head;

  logic           trig_hit;
  logic           push;
  logic           pop;
  logic [AW:0]    count_nxt;

  // The triggering instruction itself is captured, so a hit in ARMED counts as a
  // capture cycle.
  assign trig_hit  = (state_q == S_ARMED) && bus.cap_en &&
                     (bus.addr_in == bus.trig_addr);
  assign push      = bus.cap_en && !full_q &&
                     ((state_q == S_CAPTURE) || trig_hit);
  assign pop       = vld_q && bus.rd_ready;
  assign count_nxt = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.addr_in, bus.result_in};
    end
  end

  // Control: pointers, occupancy, and the capture FSM. full/valid are registered
  // from the next count, so they line up with count on every cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count_q <= count_nxt;
      full_q  <= (count_nxt == DEPTH_C);
      vld_q   <= (count_nxt != '0);

      case (state_q)
        S_IDLE: begin
          // A trigger that coincides with arm is not seen. Matching starts
          // in ARMED.
          if (bus.arm) begin
            state_q <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (trig_hit) begin
            state_q <= (count_nxt == DEPTH_C) ? S_FROZEN : S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          // Only a real fill freezes. A pop on the same edge keeps capture going.
          if (count_nxt == DEPTH_C) begin
            state_q <= S_FROZEN;
          end
        end
        S_FROZEN: begin
          if (pop && (count_q == ONE_C)) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // First-word-fall-through head. The data is forced to zero while the buffer is
  // empty, so the uninitialised memory never reaches the port.
  assign head          = mem[rd_ptr];
  assign bus.rd_valid  = vld_q;
  assign bus.rd_addr   = vld_q ? head[63:32] : 32'd0;
  assign bus.rd_result = vld_q ? head[31:0]  : 32'd0;
  assign bus.count     = count_q;
  assign bus.full      = full_q;
  assign bus.state     = state_q;

endmodule
